// File: rtl/seg7_to_bcd_capture.sv
// seg7_to_bcd_capture
//   Snoops a time-multiplexed 7-segment bus (segment lines + one-hot digit
//   selects). Each digit pattern that holds stable for STABLE_CYC samples is
//   decoded back to BCD and stored per digit. Every capture is also reported
//   as an event on a valid/ready stream.
//
//   Optional feature macro: SEG7_ACTIVE_LOW_EN
//     defined   -> seg and dig_sel are inverted in the sample stage
//                  (common-anode board); everything downstream is unchanged.
//     undefined -> seg and dig_sel are active-high.
//
//   Stream handshake: an event transfers on a rising edge where
//   out_valid && out_ready. While out_valid=1 and out_ready=0 the payload
//   (out_bcd/out_idx/out_err) is frozen. A new event on the same edge as a
//   transfer replaces the old one (out_valid stays 1). A new event while the
//   stream is stalled is dropped and sets the sticky ovf flag.
module seg7_to_bcd_capture #(
   parameter int NDIG       = 4,
   parameter int STABLE_CYC = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [6:0]           seg,
   input  logic [NDIG-1:0]      dig_sel,
   output logic [4*NDIG-1:0]    digits,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [3:0]           out_bcd,
   output logic [2:0]           out_idx,
   output logic                 out_err,
   output logic                 ovf,
   output logic [1:0]           dbg_state
);

   localparam int CW = $clog2(STABLE_CYC + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SETTLE  = 2'd1,
      S_CAPTURE = 2'd2,
      S_HOLD    = 2'd3
   } state_t;

   // Map a segment pattern to {err, bcd}; unknown patterns give {1, 4'hF}.
   function automatic logic [4:0] decode_seg(input logic [6:0] p);
      logic [4:0] r;
      case (p)
         7'h7E:   r = 5'h00;
         7'h30:   r = 5'h01;
         7'h6D:   r = 5'h02;
         7'h79:   r = 5'h03;
         7'h33:   r = 5'h04;
         7'h5B:   r = 5'h05;
         7'h5F:   r = 5'h06;
         7'h70:   r = 5'h07;
         7'h7F:   r = 5'h08;
         7'h7B:   r = 5'h09;
         default: r = 5'h1F;
      endcase
      return r;
   endfunction

   // Polarity-normalised inputs, before the sample stage.
   logic [6:0]      seg_in;
   logic [NDIG-1:0] sel_in;

   // Sample stage registers: the FSM only ever looks at these.
   logic [6:0]      seg_q;
   logic [NDIG-1:0] sel_q;

   // Last sample seen by the FSM; holds the captured pattern while in HOLD.
   logic [6:0]      last_seg_q;
   logic [NDIG-1:0] last_sel_q;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   cnt_next;
   logic [4*NDIG-1:0] digits_q;
   logic            out_valid_q;
   logic [3:0]      out_bcd_q;
   logic [2:0]      out_idx_q;
   logic            out_err_q;
   logic            ovf_q;

   // Combinational helpers derived from the sample and the stored pattern.
   logic            samp_onehot;
   logic            samp_same;
   logic [4:0]      cap_dec;
   logic [2:0]      cap_idx;

   // Input polarity normalisation.
   always_comb begin
`ifdef SEG7_ACTIVE_LOW_EN
      seg_in = ~seg;
      sel_in = ~dig_sel;
`else
      seg_in = seg;
      sel_in = dig_sel;
`endif
   end

   // Sample stage: register the bus once before any decision is made.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_q <= '0;
         sel_q <= '0;
      end else begin
         seg_q <= seg_in;
         sel_q <= sel_in;
      end
   end

   // Sample classification, decode of the stable pattern and digit index.
   always_comb begin
      samp_onehot = $onehot(sel_q);
      samp_same   = ({sel_q, seg_q} == {last_sel_q, last_seg_q});
      cnt_next    = cnt_q + CW'(1);
      cap_dec     = decode_seg(last_seg_q);
      cap_idx     = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (last_sel_q[i]) cap_idx = 3'(i);
      end
   end

   // Capture FSM plus digit store and event stream, all registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         last_seg_q  <= '0;
         last_sel_q  <= '0;
         digits_q    <= '0;
         out_valid_q <= 1'b0;
         out_bcd_q   <= '0;
         out_idx_q   <= '0;
         out_err_q   <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               last_seg_q <= seg_q;
               last_sel_q <= sel_q;
               if (samp_onehot) begin
                  state_q <= S_SETTLE;
                  cnt_q   <= CW'(1);
               end
            end
            S_SETTLE: begin
               last_seg_q <= seg_q;
               last_sel_q <= sel_q;
               if (samp_same) begin
                  cnt_q <= cnt_next;
                  if (cnt_next == CW'(STABLE_CYC)) state_q <= S_CAPTURE;
               end else if (samp_onehot) begin
                  cnt_q <= CW'(1);
               end else begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
               end
            end
            S_CAPTURE: begin
               // The stored pattern stays in last_*_q so HOLD can detect change.
               for (int i = 0; i < NDIG; i++) begin
                  if (3'(i) == cap_idx) digits_q[4*i +: 4] <= cap_dec[3:0];
               end
               state_q <= S_HOLD;
               cnt_q   <= '0;
            end
            S_HOLD: begin
               if (!samp_same) begin
                  last_seg_q <= seg_q;
                  last_sel_q <= sel_q;
                  if (samp_onehot) begin
                     state_q <= S_SETTLE;
                     cnt_q   <= CW'(1);
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               cnt_q   <= '0;
            end
         endcase

         // Event stream: load on capture unless stalled, retire on transfer.
         if (state_q == S_CAPTURE) begin
            if (!out_valid_q || out_ready) begin
               out_valid_q <= 1'b1;
               out_bcd_q   <= cap_dec[3:0];
               out_err_q   <= cap_dec[4];
               out_idx_q   <= cap_idx;
            end else begin
               ovf_q <= 1'b1;
            end
         end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign digits    = digits_q;
   assign out_valid = out_valid_q;
   assign out_bcd   = out_bcd_q;
   assign out_idx   = out_idx_q;
   assign out_err   = out_err_q;
   assign ovf       = ovf_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_seg7_to_bcd_capture.sv
// Testbench for seg7_to_bcd_capture: directed scenarios plus a randomized
// run-length scenario checked against a pattern/run reference model.
module tb_seg7_to_bcd_capture;

   localparam int NDIG = 4;
   localparam int SC   = 3;
   localparam logic [6:0] PAT [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                      7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
   localparam int DURS [5] = '{1, 2, 4, 5, 6};

   logic            clk = 1'b0;
   logic            rst;
   logic [6:0]      seg;
   logic [NDIG-1:0] dig_sel;
   logic [15:0]     digits;
   logic            out_valid;
   logic            out_ready;
   logic [3:0]      out_bcd;
   logic [2:0]      out_idx;
   logic            out_err;
   logic            ovf;
   logic [1:0]      dbg_state;

   int tests_run    = 0;
   int tests_failed = 0;

   // Event records are {err, idx[2:0], bcd[3:0]}.
   logic [7:0] obs_q[$];
   logic [7:0] exp_q[$];

   seg7_to_bcd_capture #(.NDIG(NDIG), .STABLE_CYC(SC)) dut (
      .clk(clk), .rst(rst), .seg(seg), .dig_sel(dig_sel), .digits(digits),
      .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd),
      .out_idx(out_idx), .out_err(out_err), .ovf(ovf), .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference helpers ----------------
   function automatic logic [4:0] ref_decode(input logic [6:0] p);
      for (int i = 0; i < 10; i++) begin
         if (PAT[i] == p) return {1'b0, 4'(i)};
      end
      return 5'h1F;
   endfunction

   // ---------------- drivers ----------------
   task automatic drive(input logic [NDIG-1:0] sel, input logic [6:0] s);
`ifdef SEG7_ACTIVE_LOW_EN
      dig_sel = ~sel;
      seg     = ~s;
`else
      dig_sel = sel;
      seg     = s;
`endif
   endtask

   // Advance n cycles; record every handshake seen at the falling edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         if (out_valid && out_ready) obs_q.push_back({out_err, out_idx, out_bcd});
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst = 1'b1;
      out_ready = 1'b1;
      drive('0, '0);
      tick(3);
      rst = 1'b0;
      tests_run++; if (digits !== 16'h0) begin tests_failed++; $display("FAIL reset_digits: got %h expected 0", digits); end
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      tests_run++; if (out_bcd !== 4'h0) begin tests_failed++; $display("FAIL reset_bcd: got %h expected 0", out_bcd); end
      tests_run++; if (out_idx !== 3'h0) begin tests_failed++; $display("FAIL reset_idx: got %h expected 0", out_idx); end
      tests_run++; if (out_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", out_err); end
      tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
      tick(2);
   endtask

   task automatic test_single;
      int rise;
      rise = -1;
      obs_q.delete();
      drive(4'b0001, 7'h5B);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (out_valid && rise < 0) rise = k;
         if (out_valid && out_ready) obs_q.push_back({out_err, out_idx, out_bcd});
         if (k == 5) drive('0, '0);
      end
      tests_run++; if (rise != SC + 1) begin tests_failed++; $display("FAIL single_latency: got %0d expected %0d", rise, SC + 1); end
      tests_run++;
      if (obs_q.size() != 1) begin tests_failed++; $display("FAIL single_count: got %0d expected 1", obs_q.size()); end
      else if (obs_q[0] !== {1'b0, 3'd0, 4'd5}) begin tests_failed++; $display("FAIL single_event: got %h expected %h", obs_q[0], {1'b0, 3'd0, 4'd5}); end
      tests_run++; if (digits[3:0] !== 4'd5) begin tests_failed++; $display("FAIL single_digit: got %h expected 5", digits[3:0]); end
   endtask

   task automatic test_scan;
      logic [6:0] pats [4];
      pats = '{7'h30, 7'h6D, 7'h79, 7'h33};
      obs_q.delete();
      for (int d = 0; d < 4; d++) begin
         drive(4'(1 << d), pats[d]);
         tick(5);
      end
      drive('0, '0);
      tick(6);
      tests_run++; if (digits !== 16'h4321) begin tests_failed++; $display("FAIL scan_digits: got %h expected 4321", digits); end
      tests_run++;
      if (obs_q.size() != 4) begin tests_failed++; $display("FAIL scan_count: got %0d expected 4", obs_q.size()); end
      else begin
         for (int d = 0; d < 4; d++) begin
            tests_run++;
            if (obs_q[d] !== {1'b0, 3'(d), 4'(d + 1)}) begin
               tests_failed++; $display("FAIL scan_event%0d: got %h expected %h", d, obs_q[d], {1'b0, 3'(d), 4'(d + 1)});
            end
         end
      end
   endtask

   task automatic test_glitch;
      obs_q.delete();
      drive(4'b0100, 7'h0F); tick(2);
      drive(4'b0100, 7'h7F); tick(4);
      drive('0, '0);         tick(6);
      tests_run++;
      if (obs_q.size() != 1) begin tests_failed++; $display("FAIL glitch_count: got %0d expected 1", obs_q.size()); end
      else if (obs_q[0] !== {1'b0, 3'd2, 4'd8}) begin tests_failed++; $display("FAIL glitch_event: got %h expected %h", obs_q[0], {1'b0, 3'd2, 4'd8}); end
      tests_run++; if (digits[11:8] !== 4'd8) begin tests_failed++; $display("FAIL glitch_digit: got %h expected 8", digits[11:8]); end
      // A one-cycle glitch splits two short runs; neither may capture.
      obs_q.delete();
      drive(4'b0100, 7'h7F); tick(2);
      drive(4'b0100, 7'h7E); tick(1);
      drive(4'b0100, 7'h7F); tick(2);
      drive('0, '0);         tick(6);
      tests_run++; if (obs_q.size() != 0) begin tests_failed++; $display("FAIL glitch_restart: got %0d events expected 0", obs_q.size()); end
   endtask

   task automatic test_illegal;
      obs_q.delete();
      drive(4'b0010, 7'h01); tick(6);
      drive('0, '0);         tick(6);
      tests_run++;
      if (obs_q.size() != 1) begin tests_failed++; $display("FAIL illegal_count: got %0d expected 1", obs_q.size()); end
      else if (obs_q[0] !== {1'b1, 3'd1, 4'hF}) begin tests_failed++; $display("FAIL illegal_event: got %h expected %h", obs_q[0], {1'b1, 3'd1, 4'hF}); end
      tests_run++; if (digits[7:4] !== 4'hF) begin tests_failed++; $display("FAIL illegal_digit: got %h expected f", digits[7:4]); end
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0;
      obs_q.delete();
      drive(4'b0001, 7'h7E); tick(6);
      drive('0, '0);         tick(3);
      tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_pending: got %b expected 1", out_valid); end
      tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL bp_ovf_pre: got %b expected 0", ovf); end
      drive(4'b1000, 7'h70);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         tests_run++;
         if ({out_valid, out_err, out_idx, out_bcd} !== {1'b1, 1'b0, 3'd0, 4'd0}) begin
            tests_failed++; $display("FAIL bp_hold%0d: got %h expected %h", k, {out_valid, out_err, out_idx, out_bcd}, {1'b1, 1'b0, 3'd0, 4'd0});
         end
         if (k == 5) drive('0, '0);
      end
      tests_run++; if (ovf !== 1'b1) begin tests_failed++; $display("FAIL bp_ovf_set: got %b expected 1", ovf); end
      tests_run++; if (digits[15:12] !== 4'd7) begin tests_failed++; $display("FAIL bp_digit: got %h expected 7", digits[15:12]); end
      out_ready = 1'b1;
      if (out_valid && out_ready) obs_q.push_back({out_err, out_idx, out_bcd});
      tick(2);
      tests_run++;
      if (obs_q.size() != 1) begin tests_failed++; $display("FAIL bp_count: got %0d expected 1", obs_q.size()); end
      else if (obs_q[0] !== {1'b0, 3'd0, 4'd0}) begin tests_failed++; $display("FAIL bp_event: got %h expected 0", obs_q[0]); end
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
      tests_run++; if (ovf !== 1'b1) begin tests_failed++; $display("FAIL bp_ovf_sticky: got %b expected 1", ovf); end
   endtask

   task automatic test_async_reset;
      int rise;
      out_ready = 1'b0;
      drive(4'b0001, 7'h30); tick(6);
      tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL ar_pending: got %b expected 1", out_valid); end
      #2 rst = 1'b1;
      #1;
      tests_run++; if (digits !== 16'h0) begin tests_failed++; $display("FAIL ar_digits: got %h expected 0", digits); end
      tests_run++; if ({out_valid, out_err, out_idx, out_bcd} !== 9'h0) begin tests_failed++; $display("FAIL ar_stream: got %h expected 0", {out_valid, out_err, out_idx, out_bcd}); end
      tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL ar_ovf: got %b expected 0", ovf); end
      tick(2);
      rst = 1'b0;
      out_ready = 1'b1;
      rise = -1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (out_valid && rise < 0) rise = k;
      end
      tests_run++; if (rise != SC + 1) begin tests_failed++; $display("FAIL ar_release_latency: got %0d expected %0d", rise, SC + 1); end
      // Reset in the middle of a settle period.
      drive(4'b0010, 7'h6D); tick(2);
      #2 rst = 1'b1;
      tick(1);
      rst = 1'b0;
      rise = -1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (out_valid && rise < 0) begin
            rise = k;
            tests_run++;
            if ({out_idx, out_bcd} !== {3'd1, 4'd2}) begin tests_failed++; $display("FAIL ar_settle_event: got %h expected %h", {out_idx, out_bcd}, {3'd1, 4'd2}); end
         end
      end
      tests_run++; if (rise != SC + 1) begin tests_failed++; $display("FAIL ar_settle_latency: got %0d expected %0d", rise, SC + 1); end
      drive('0, '0); tick(6);
   endtask

   task automatic test_back_to_back;
      out_ready = 1'b0;
      drive(4'b0001, 7'h33); tick(6);
      drive('0, '0);         tick(3);
      drive(4'b0010, 7'h5B);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 3) begin
            out_ready = 1'b1;
            tests_run++;
            if ({out_valid, out_bcd} !== {1'b1, 4'd4}) begin tests_failed++; $display("FAIL b2b_old: got %h expected %h", {out_valid, out_bcd}, {1'b1, 4'd4}); end
         end
         if (k == 4) begin
            tests_run++;
            if ({out_valid, out_idx, out_bcd, ovf} !== {1'b1, 3'd1, 4'd5, 1'b0}) begin
               tests_failed++; $display("FAIL b2b_replace: got %h expected %h", {out_valid, out_idx, out_bcd, ovf}, {1'b1, 3'd1, 4'd5, 1'b0});
            end
         end
         if (k == 5) begin
            tests_run++;
            if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
            drive('0, '0);
         end
      end
      tick(4);
   endtask

   task automatic test_random;
      logic [NDIG-1:0] sel;
      logic [6:0]      s;
      logic [10:0]     prev;
      logic [3:0]      exp_digits [NDIG];
      logic [2:0]      idx;
      logic [4:0]      dec;
      int              dur;
      int              n;
      rst = 1'b1;
      drive('0, '0);
      tick(2);
      rst = 1'b0;
      tick(2);
      out_ready = 1'b1;
      obs_q.delete();
      exp_q.delete();
      for (int i = 0; i < NDIG; i++) exp_digits[i] = 4'h0;
      prev = '0;
      for (int r = 0; r < 40; r++) begin
         do begin
            if ($urandom_range(0, 9) < 7) sel = 4'(1 << $urandom_range(0, NDIG - 1));
            else sel = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) != 0) s = PAT[$urandom_range(0, 9)];
            else s = 7'($urandom_range(0, 127));
         end while ({sel, s} == prev);
         prev = {sel, s};
         dur = DURS[$urandom_range(0, 4)];
         // A one-hot pattern held for at least SC samples is one capture.
         if ($onehot(sel) && dur >= SC) begin
            idx = '0;
            for (int i = 0; i < NDIG; i++) if (sel[i]) idx = 3'(i);
            dec = ref_decode(s);
            exp_q.push_back({dec[4], idx, dec[3:0]});
            exp_digits[idx] = dec[3:0];
         end
         drive(sel, s);
         tick(dur);
      end
      drive('0, '0);
      tick(8);
      tests_run++;
      if (obs_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL rand_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         tests_run++;
         if (obs_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL rand_event%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
      end
      for (int i = 0; i < NDIG; i++) begin
         tests_run++;
         if (digits[4*i +: 4] !== exp_digits[i]) begin tests_failed++; $display("FAIL rand_digit%0d: got %h expected %h", i, digits[4*i +: 4], exp_digits[i]); end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single();
      test_scan();
      test_glitch();
      test_illegal();
      test_backpressure();
      test_async_reset();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
